// File: rtl/l1c_axi_line_fill.sv
// Cache-miss line-fill master: one AXI read burst per miss, critical word forwarded
// to the CPU as soon as it lands, full line handed to the cache on completion.
module l1c_axi_line_fill #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int ID_W       = 4,
  parameter int AR_ID      = 0,
  parameter int WRAP_EN    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         crit_valid,
  output logic [DATA_W-1:0]            crit_data,
  output logic                         crit_err,
  output logic                         fill_valid,
  output logic [ADDR_W-1:0]            fill_addr,
  output logic [LINE_WORDS*DATA_W-1:0] fill_data,
  output logic                         fill_err,
  output logic                         busy,
  output logic [ID_W-1:0]              ARID,
  output logic [ADDR_W-1:0]            ARADDR,
  output logic [7:0]                   ARLEN,
  output logic [2:0]                   ARSIZE,
  output logic [1:0]                   ARBURST,
  output logic                         ARVALID,
  input  logic                         ARREADY,
  input  logic [ID_W-1:0]              RID,
  input  logic [DATA_W-1:0]            RDATA,
  input  logic [1:0]                   RRESP,
  input  logic                         RLAST,
  input  logic                         RVALID,
  output logic                         RREADY
);

  localparam int SZ     = $clog2(DATA_W / 8);
  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int OFF_W  = SZ + IDX_W;
  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((64'd1 << SZ) - 64'd1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [IDX_W:0]    CNT_MAX   = (IDX_W + 1)'(LINE_WORDS);
  localparam logic [IDX_W:0]    CNT_LAST  = (IDX_W + 1)'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]    ws_q, ws_d;
  logic [IDX_W:0]      cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                crit_seen_q, crit_seen_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                crit_valid_q, crit_valid_d;
  logic [DATA_W-1:0]   crit_data_q, crit_data_d;
  logic                crit_err_q, crit_err_d;
  logic                fill_valid_q, fill_valid_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic [LINE_W-1:0]   fill_data_q, fill_data_d;
  logic                fill_err_q, fill_err_d;

  logic                beat_s;
  logic                beat_err_s;
  logic                in_range_s;
  logic                err_next_s;
  logic [IDX_W-1:0]    slot_s;
  logic                unused_rresp0;

  assign unused_rresp0 = RRESP[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      ws_q         <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      crit_seen_q  <= 1'b0;
      line_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      crit_err_q   <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      fill_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      ws_q         <= ws_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      crit_seen_q  <= crit_seen_d;
      line_q       <= line_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      crit_err_q   <= crit_err_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      fill_err_q   <= fill_err_d;
    end
  end

  // A beat lands in slot (ws+cnt) for WRAP, slot cnt for INCR; the critical word is slot ws.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ws_d         = ws_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    crit_seen_d  = crit_seen_q;
    line_d       = line_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    crit_err_d   = 1'b0;
    fill_valid_d = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    fill_err_d   = 1'b0;

    beat_s     = (state_q == S_R) && RVALID;
    beat_err_s = RRESP[1] | (RID != ID_W'(AR_ID));
    in_range_s = (cnt_q < CNT_MAX);
    slot_s     = (WRAP_EN != 0) ? (ws_q + cnt_q[IDX_W-1:0]) : cnt_q[IDX_W-1:0];
    err_next_s = err_q | beat_err_s | ~in_range_s | (RLAST && (cnt_q != CNT_LAST));

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr & WORD_MASK;
          ws_d        = req_addr[SZ +: IDX_W];
          cnt_d       = '0;
          err_d       = 1'b0;
          crit_seen_d = 1'b0;
          line_d      = '0;
          state_d     = S_AR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        if (ARREADY) begin
          state_d = S_R;
        end else begin
          state_d = S_AR;
        end
      end
      S_R: begin
        if (beat_s) begin
          err_d = err_next_s;
          if (in_range_s) begin
            line_d[int'(slot_s) * DATA_W +: DATA_W] = RDATA;
            cnt_d = cnt_q + (IDX_W + 1)'(1);
            if ((slot_s == ws_q) && !crit_seen_q) begin
              crit_valid_d = 1'b1;
              crit_data_d  = RDATA;
              crit_err_d   = beat_err_s;
              crit_seen_d  = 1'b1;
            end else begin
              crit_seen_d = crit_seen_q;
            end
          end else begin
            cnt_d = cnt_q;
          end
          if (RLAST) begin
            state_d      = S_DONE;
            fill_valid_d = 1'b1;
            fill_addr_d  = addr_q & LINE_MASK;
            fill_data_d  = line_d;
            fill_err_d   = err_next_s;
          end else begin
            state_d = S_R;
          end
        end else begin
          state_d = S_R;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign crit_err   = crit_err_q;
  assign fill_valid = fill_valid_q;
  assign fill_addr  = fill_addr_q;
  assign fill_data  = fill_data_q;
  assign fill_err   = fill_err_q;

  // AR fields come only from the latched address and constants, so they stay put until ARREADY.
  assign ARVALID = (state_q == S_AR);
  assign ARID    = ID_W'(AR_ID);
  assign ARLEN   = 8'(LINE_WORDS - 1);
  assign ARSIZE  = 3'(SZ);
  assign ARBURST = (WRAP_EN != 0) ? 2'b10 : 2'b01;
  assign ARADDR  = (state_q != S_AR) ? '0 :
                   ((WRAP_EN != 0) ? addr_q : (addr_q & LINE_MASK));
  assign RREADY  = (state_q == S_R);

endmodule

// File: tb/tb_l1c_axi_line_fill.sv
// Directed bench: three line-fill instances (WRAP/4 words, INCR/4 words, WRAP/8 words)
// share the AXI slave stimulus; only the selected instance is given a request.
module tb_l1c_axi_line_fill;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [31:0] req_addr;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic [1:0]  sel;

  logic        req_ready_w  [3];
  logic        crit_valid_w [3];
  logic [31:0] crit_data_w  [3];
  logic        crit_err_w   [3];
  logic        fill_valid_w [3];
  logic [31:0] fill_addr_w  [3];
  logic [255:0] fdata_w     [3];
  logic        fill_err_w   [3];
  logic        busy_w       [3];
  logic [3:0]  arid_w       [3];
  logic [31:0] araddr_w     [3];
  logic [7:0]  arlen_w      [3];
  logic [2:0]  arsize_w     [3];
  logic [1:0]  arburst_w    [3];
  logic        arvalid_w    [3];
  logic        rready_w     [3];

  int n_chk;
  int n_fail;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LW = (g == 2) ? 8 : 4;
    localparam int WR = (g == 1) ? 0 : 1;
    logic [LW*32-1:0] fd;
    l1c_axi_line_fill #(
      .ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW), .ID_W(4), .AR_ID(0), .WRAP_EN(WR)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready_w[g]), .req_addr(req_addr),
      .crit_valid(crit_valid_w[g]), .crit_data(crit_data_w[g]), .crit_err(crit_err_w[g]),
      .fill_valid(fill_valid_w[g]), .fill_addr(fill_addr_w[g]), .fill_data(fd),
      .fill_err(fill_err_w[g]), .busy(busy_w[g]),
      .ARID(arid_w[g]), .ARADDR(araddr_w[g]), .ARLEN(arlen_w[g]), .ARSIZE(arsize_w[g]),
      .ARBURST(arburst_w[g]), .ARVALID(arvalid_w[g]), .ARREADY(arready),
      .RID(rid), .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid),
      .RREADY(rready_w[g])
    );
    assign fdata_w[g] = 256'(fd);
  end

  wire        o_req_ready  = req_ready_w[sel];
  wire        o_crit_valid = crit_valid_w[sel];
  wire [31:0] o_crit_data  = crit_data_w[sel];
  wire        o_crit_err   = crit_err_w[sel];
  wire        o_fill_valid = fill_valid_w[sel];
  wire [31:0] o_fill_addr  = fill_addr_w[sel];
  wire [255:0] o_fill_data = fdata_w[sel];
  wire        o_fill_err   = fill_err_w[sel];
  wire        o_busy       = busy_w[sel];
  wire [3:0]  o_arid       = arid_w[sel];
  wire [31:0] o_araddr     = araddr_w[sel];
  wire [7:0]  o_arlen      = arlen_w[sel];
  wire [2:0]  o_arsize     = arsize_w[sel];
  wire [1:0]  o_arburst    = arburst_w[sel];
  wire        o_arvalid    = arvalid_w[sel];
  wire        o_rready     = rready_w[sel];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] s, input logic [31:0] a);
    sel          = s;
    req_addr     = a;
    req_valid[s] = 1'b1;
    step();
    req_valid[s] = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id,
                      input logic last);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = resp;
    rid    = id;
    rlast  = last;
    step();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    rid    = 4'h0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 3'b000;
    req_addr  = 32'h0;
    arready   = 1'b1;
    rid       = 4'h0;
    rdata     = 32'h0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;
    sel       = 2'd0;
    step();
    step();

    // reset state
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_flags", {o_req_ready, o_busy, o_arvalid, o_rready, o_crit_valid, o_fill_valid,
                        o_fill_err, o_crit_err}, {1'b1, 1'b0, 6'b000000});
      chk("rst_data", {o_fill_data, o_crit_data, o_araddr}, 256'h0);
    end
    rst = 1'b0;
    step();

    // WRAP, 4 words, req 0x1008: beats to slots 2,3,0,1
    request(2'd0, 32'h0000_1008);
    chk("s1_ar", {o_arvalid, o_arid, o_araddr, o_arburst, o_arlen, o_arsize, o_req_ready, o_busy},
        {1'b1, 4'h0, 32'h0000_1008, 2'b10, 8'd3, 3'd2, 1'b0, 1'b1});
    step();
    chk("s1_r", {o_rready, o_arvalid, o_araddr, o_crit_valid}, {1'b1, 1'b0, 32'h0, 1'b0});
    beat(32'hA000_0002, 2'b00, 4'h0, 1'b0);
    chk("s1_crit", {o_crit_valid, o_crit_data, o_crit_err}, {1'b1, 32'hA000_0002, 1'b0});
    beat(32'hA000_0003, 2'b00, 4'h0, 1'b0);
    chk("s1_crit_once", o_crit_valid, 256'h0);
    beat(32'hA000_0000, 2'b00, 4'h0, 1'b0);
    chk("s1_no_fill_early", o_fill_valid, 256'h0);
    beat(32'hA000_0001, 2'b00, 4'h0, 1'b1);
    chk("s1_fill", {o_fill_valid, o_fill_err, o_fill_addr}, {1'b1, 1'b0, 32'h0000_1000});
    chk("s1_fill_data", o_fill_data, 256'hA0000003_A0000002_A0000001_A0000000);
    step();
    chk("s1_idle", {o_fill_valid, o_req_ready, o_busy}, {1'b0, 1'b1, 1'b0});
    chk("s1_hold", o_fill_data, 256'hA0000003_A0000002_A0000001_A0000000);

    // INCR, 4 words, req 0x200C: critical word is the last beat
    request(2'd1, 32'h0000_200C);
    chk("s2_ar", {o_araddr, o_arburst, o_arlen}, {32'h0000_2000, 2'b01, 8'd3});
    step();
    beat(32'hD000_0000, 2'b00, 4'h0, 1'b0);
    req_valid[1] = 1'b1;
    beat(32'hD000_0001, 2'b00, 4'h0, 1'b0);
    req_valid[1] = 1'b0;
    chk("s2_req_ignored", {o_arvalid, o_rready, o_req_ready}, {1'b0, 1'b1, 1'b0});
    beat(32'hD000_0002, 2'b00, 4'h0, 1'b0);
    chk("s2_no_crit_yet", o_crit_valid, 256'h0);
    beat(32'hD000_0003, 2'b00, 4'h0, 1'b1);
    chk("s2_crit_fill", {o_crit_valid, o_crit_data, o_fill_valid, o_fill_err, o_fill_addr},
        {1'b1, 32'hD000_0003, 1'b1, 1'b0, 32'h0000_2000});
    chk("s2_fill_data", o_fill_data, 256'hD0000003_D0000002_D0000001_D0000000);
    step();

    // ARREADY held low 5 cycles, then RRESP error on non-critical beat 1
    arready = 1'b0;
    request(2'd0, 32'h0000_1104);
    for (int i = 0; i < 5; i++) begin
      chk("s3_ar_hold", {o_arvalid, o_rready, o_arburst, o_arlen, o_arsize, o_araddr},
          {1'b1, 1'b0, 2'b10, 8'd3, 3'd2, 32'h0000_1104});
      step();
    end
    arready = 1'b1;
    chk("s3_ar_last", {o_arvalid, o_rready, o_araddr}, {1'b1, 1'b0, 32'h0000_1104});
    step();
    chk("s3_rready", o_rready, 256'h1);
    beat(32'hB000_0001, 2'b00, 4'h0, 1'b0);
    chk("s3_crit", {o_crit_valid, o_crit_data, o_crit_err}, {1'b1, 32'hB000_0001, 1'b0});
    beat(32'hB000_0002, 2'b10, 4'h0, 1'b0);
    beat(32'hB000_0003, 2'b00, 4'h0, 1'b0);
    beat(32'hB000_0000, 2'b00, 4'h0, 1'b1);
    chk("s3_fill", {o_fill_valid, o_fill_err, o_fill_addr}, {1'b1, 1'b1, 32'h0000_1100});
    chk("s3_fill_data", o_fill_data, 256'hB0000003_B0000002_B0000001_B0000000);
    step();

    // short burst: RLAST on the third beat of four
    request(2'd0, 32'h0000_3004);
    step();
    beat(32'hC000_0001, 2'b00, 4'h0, 1'b0);
    chk("s4_crit", {o_crit_valid, o_crit_err}, {1'b1, 1'b0});
    beat(32'hC000_0002, 2'b00, 4'h0, 1'b0);
    beat(32'hC000_0003, 2'b00, 4'h0, 1'b1);
    chk("s4_short", {o_fill_valid, o_fill_err, o_fill_addr}, {1'b1, 1'b1, 32'h0000_3000});
    step();
    chk("s4_idle", {o_busy, o_fill_valid}, {1'b0, 1'b0});

    // RID mismatch on the critical beat (INCR, ws=0)
    request(2'd1, 32'h0000_5000);
    step();
    beat(32'hF000_0000, 2'b00, 4'h3, 1'b0);
    chk("s6_crit_rid", {o_crit_valid, o_crit_data, o_crit_err}, {1'b1, 32'hF000_0000, 1'b1});
    beat(32'hF000_0001, 2'b00, 4'h0, 1'b0);
    beat(32'hF000_0002, 2'b00, 4'h0, 1'b0);
    beat(32'hF000_0003, 2'b00, 4'h0, 1'b1);
    chk("s6_fill_rid", {o_fill_valid, o_fill_err}, {1'b1, 1'b1});
    step();

    // 8-word line: reset during beat 3, then a clean fill
    request(2'd2, 32'h0000_4014);
    chk("s5_ar", {o_araddr, o_arlen, o_arburst}, {32'h0000_4014, 8'd7, 2'b10});
    step();
    beat(32'hE000_0005, 2'b00, 4'h0, 1'b0);
    chk("s5_crit", {o_crit_valid, o_crit_data}, {1'b1, 32'hE000_0005});
    beat(32'hE000_0006, 2'b00, 4'h0, 1'b0);
    beat(32'hE000_0007, 2'b00, 4'h0, 1'b0);
    rvalid = 1'b1;
    rdata  = 32'hE000_0000;
    #2;
    rst = 1'b1;
    #1;
    chk("s5_rst_idle", {o_busy, o_req_ready, o_rready, o_arvalid, o_fill_valid, o_crit_valid},
        {1'b0, 1'b1, 4'b0000});
    chk("s5_rst_data", {o_fill_data[223:0], o_crit_data}, 256'h0);
    step();
    rst    = 1'b0;
    rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s5_no_pulse", {o_fill_valid, o_crit_valid, o_busy}, {3'b000});
    end
    request(2'd2, 32'h0000_4000);
    step();
    for (int k = 0; k < 8; k++) begin
      beat(32'hE000_0000 | 32'(k), 2'b00, 4'h0, (k == 7) ? 1'b1 : 1'b0);
      if (k == 0) begin
        chk("s5b_crit", {o_crit_valid, o_crit_data, o_crit_err}, {1'b1, 32'hE000_0000, 1'b0});
      end else if (k < 7) begin
        chk("s5b_no_fill", {o_fill_valid, o_crit_valid}, {2'b00});
      end else begin
        chk("s5b_fill", {o_fill_valid, o_fill_err, o_fill_addr}, {1'b1, 1'b0, 32'h0000_4000});
      end
    end
    chk("s5b_fill_data", o_fill_data,
        256'hE0000007_E0000006_E0000005_E0000004_E0000003_E0000002_E0000001_E0000000);
    step();
    chk("s5b_idle", {o_fill_valid, o_busy, o_req_ready}, {1'b0, 1'b0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
